hps_pio_edge: RTL and testbench

HPS_PIO_EDGE -- requirements
Module: hps_pio_edge

---
 rtl/hps_pio_edge.sv | 80 ++++++++
 tb/tb_hps_pio_edge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hps_pio_edge.sv
// hps_pio_edge: Avalon-MM PIO slave with synchronised inputs, edge capture with write-1-to-clear,
// maskable interrupt and a shared output register at addresses 0 and 1.
module hps_pio_edge #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE = 0,
    parameter logic [DATA_WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);
    localparam logic [2:0] PRIMED = 3'(SYNC_STAGES + 1);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] cap_q, cap_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [2:0]            prime_q, prime_d;
    logic [DATA_WIDTH-1:0] sync, rise, fall, edge_det, wd, clr, rd_sel;
    logic                  wr, primed;
    logic                  unused_wd;

    assign unused_wd = ^writedata;
    assign sync      = sync_q[SYNC_STAGES-1];
    assign primed    = prime_q == PRIMED;
    assign wr        = chipselect && !write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d   = sync;
        prime_d  = primed ? prime_q : prime_q + 3'd1;
        rise     = sync & ~prev_q;
        fall     = ~sync & prev_q;
        // Until prev holds a real sample, sync/prev differences are reset artefacts.
        edge_det = !primed ? '0 : EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
        clr      = (wr && address == 2'd3) ? wd : '0;
        cap_d    = (cap_q & ~clr) | edge_det;
        out_d    = (wr && !address[1]) ? wd : out_q;
        mask_d   = (wr && address == 2'd2) ? wd : mask_q;
        rd_sel   = address == 2'd0 ? sync : address == 2'd1 ? out_q : address == 2'd2 ? mask_q : cap_q;
        readdata_d = 32'(rd_sel);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
            out_q      <= OUT_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            prev_q     <= prev_d;
            prime_q    <= prime_d;
            out_q      <= out_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_q;
    assign irq      = |(cap_q & mask_q);
endmodule

// File: tb/tb_hps_pio_edge.sv
// tb_hps_pio_edge: drives rising, falling and any-edge instances with shared stimulus and
// compares them to a history-based reference model of the register map.
module tb_hps_pio_edge;
    localparam int S = 2;

    logic        clk = 0;
    logic        reset = 1;
    logic [1:0]  address = 0;
    logic        chipselect = 0;
    logic        write_n = 1;
    logic [31:0] writedata = 0;
    logic [7:0]  in_port = 8'hA5;
    logic [31:0] rd_w [3];
    logic [7:0]  op_w [3];
    logic        irq_w [3];

    int total = 0;
    int bad = 0;

    logic [7:0]  hist [$];
    logic [7:0]  out_m [3];
    logic [7:0]  mask_m [3];
    logic [7:0]  cap_m [3];
    logic [31:0] rd_m [3];

    always #5 clk = ~clk;

    hps_pio_edge #(.EDGE_TYPE(0)) u_r (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_w[0]), .in_port(in_port), .out_port(op_w[0]), .irq(irq_w[0]));
    hps_pio_edge #(.EDGE_TYPE(1)) u_f (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_w[1]), .in_port(in_port), .out_port(op_w[1]), .irq(irq_w[1]));
    hps_pio_edge #(.EDGE_TYPE(2), .OUT_RESET(8'h5A)) u_a (.clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_w[2]), .in_port(in_port), .out_port(op_w[2]), .irq(irq_w[2]));

    function automatic logic [7:0] orst(int t);
        return t == 2 ? 8'h5A : 8'h00;
    endfunction

    function automatic logic [7:0] hv(int i);
        return (i >= 1 && i < hist.size()) ? hist[i] : 8'h00;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist = {};
        hist.push_back(8'h00);
        for (int t = 0; t < 3; t++) begin
            out_m[t] = orst(t); mask_m[t] = 0; cap_m[t] = 0; rd_m[t] = 0;
        end
    endtask

    task automatic check_all();
        for (int t = 0; t < 3; t++) begin
            check($sformatf("rd%0d", t), rd_w[t], rd_m[t]);
            check($sformatf("out%0d", t), {24'h0, op_w[t]}, {24'h0, out_m[t]});
            check($sformatf("irq%0d", t), {31'h0, irq_w[t]}, {31'h0, |(cap_m[t] & mask_m[t])});
        end
    endtask

    // Edge k samples in_port into hist[k]; the synchronised value seen at edge k is hist[k-S],
    // and edges count only once both compared samples were taken after reset.
    task automatic tick();
        logic [7:0] s, p, wd, clr;
        logic [7:0] ev [3];
        int k;
        bit wr;
        hist.push_back(in_port);
        k  = hist.size() - 1;
        s  = hv(k - S);
        p  = hv(k - S - 1);
        ev[0] = (k >= S + 2) ? (s & ~p) : 8'h00;
        ev[1] = (k >= S + 2) ? (~s & p) : 8'h00;
        ev[2] = (k >= S + 2) ? (s ^ p) : 8'h00;
        wr  = chipselect && !write_n;
        wd  = writedata[7:0];
        clr = (wr && address == 3) ? wd : 8'h00;
        for (int t = 0; t < 3; t++) begin
            rd_m[t] = {24'h0, address == 0 ? s : address == 1 ? out_m[t] : address == 2 ? mask_m[t] : cap_m[t]};
            if (wr && address < 2) out_m[t] = wd;
            if (wr && address == 2) mask_m[t] = wd;
            cap_m[t] = (cap_m[t] & ~clr) | ev[t];
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr_reg(logic [1:0] a, logic [31:0] d);
        address = a; chipselect = 1; write_n = 0; writedata = d;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    task automatic idle(int n, logic [1:0] a);
        address = a;
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        #2 reset = 1;
        #1;
        model_reset();
        for (int t = 0; t < 3; t++) begin
            check("rst_rd", rd_w[t], 32'h0);
            check("rst_out", {24'h0, op_w[t]}, {24'h0, orst(t)});
            check("rst_irq", {31'h0, irq_w[t]}, 32'h0);
        end
        @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) check("rst_hold_out", {24'h0, op_w[t]}, {24'h0, orst(t)});
        chipselect = 0; write_n = 1;
        reset = 0;
    endtask

    initial begin
        model_reset();
        #12;
        for (int t = 0; t < 3; t++) begin
            check("init_rd", rd_w[t], 32'h0);
            check("init_out", {24'h0, op_w[t]}, {24'h0, orst(t)});
            check("init_irq", {31'h0, irq_w[t]}, 32'h0);
        end
        @(posedge clk);
        #1 reset = 0;
        model_reset();

        idle(4, 0);
        check("static_a5", rd_w[0], 32'h0000_00A5);
        idle(1, 3);
        check("static_cap", rd_w[0], 32'h0);
        check("static_irq", {31'h0, irq_w[0]}, 32'h0);

        in_port = 8'hA4;
        idle(4, 3);
        wr_reg(2, 32'h01);
        wr_reg(3, 32'hFF);
        in_port = 8'hA5;
        idle(4, 3);
        check("rise_cap", rd_w[0], 32'h01);
        check("rise_irq", {31'h0, irq_w[0]}, 32'h1);
        wr_reg(3, 32'h01);
        check("clr_irq", {31'h0, irq_w[0]}, 32'h0);

        in_port = 8'hAD;
        idle(4, 3);
        wr_reg(3, 32'hFF);
        in_port = 8'hA5;
        idle(4, 3);
        in_port = 8'hAD;
        idle(4, 3);
        check("fall_cap", rd_w[1], 32'h08);

        in_port = 8'hA9;
        idle(4, 3);
        wr_reg(3, 32'hFF);
        in_port = 8'hAD;
        idle(2, 3);
        wr_reg(3, 32'h04);
        idle(1, 3);
        check("set_wins", {31'h0, rd_w[0][2]}, 32'h1);

        wr_reg(0, 32'hFFFF_FF3C);
        check("out_3c", {24'h0, op_w[0]}, 32'h3C);
        idle(2, 1);
        check("rb_3c", rd_w[0], 32'h0000_003C);

        wr_reg(2, 32'hFF);
        wr_reg(3, 32'hFF);
        in_port = ~in_port;
        idle(4, 3);
        check("any_cap", rd_w[2], 32'hFF);
        check("any_irq", {31'h0, irq_w[2]}, 32'h1);
        address = 0; chipselect = 1; write_n = 0; writedata = 32'h77;
        pulse_reset();
        model_reset();
        idle(6, 3);
        check("reprime_cap", rd_w[2], 32'h0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) in_port = 8'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = $urandom_range(2) != 0;
            writedata  = $urandom;
            tick();
            if (i == 200) begin
                chipselect = 1; write_n = 0;
                pulse_reset();
                model_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
